// File: rtl/pipe_id_stage_fwd.sv
// Decode stage: register file, operand forwarding from EX/MEM/WB, load-use
// hazard detection and the ID/EX pipeline register.
module pipe_id_stage_fwd #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CTRL_W = 16,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic [ADDR_W-1:0] id_dst,
   input  logic              id_regwr,
   input  logic              id_memrd,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              mem_regwr,
   input  logic [ADDR_W-1:0] mem_dst,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              wb_wr,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              stall_out,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc,
   output logic [ADDR_W-1:0] ex_dst,
   output logic              ex_regwr,
   output logic              ex_memrd,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_regs [NREG];

   logic              r_ex_valid;
   logic [CTRL_W-1:0] r_ex_ctrl;
   logic [DATA_W-1:0] r_ex_a;
   logic [DATA_W-1:0] r_ex_b;
   logic [DATA_W-1:0] r_ex_imm;
   logic [DATA_W-1:0] r_ex_pc;
   logic [ADDR_W-1:0] r_ex_dst;
   logic              r_ex_regwr;
   logic              r_ex_memrd;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_ex_fwd_ok;
   logic              w_mem_fwd_ok;
   logic              w_wb_fwd_ok;
   logic              w_ex_hit;
   logic              w_mem_hit;
   logic              w_load_use;
   logic              w_ex_raw;
   logic              w_mem_raw;
   logic              w_hazard;
   logic              w_stall;
   logic              w_bubble;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;

   // Register 0 is never written, so it stays at its reset value of 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (wb_wr && (wb_addr != '0)) begin
         r_regs[wb_addr] <= wb_data;
      end
   end

   assign w_ex_fwd_ok  = r_ex_valid & r_ex_regwr & ~r_ex_memrd & (r_ex_dst != '0);
   assign w_mem_fwd_ok = mem_regwr & (mem_dst != '0);
   assign w_wb_fwd_ok  = wb_wr & (wb_addr != '0);

   // Youngest producer wins; WB write-through is used even without forwarding.
   function automatic logic [DATA_W-1:0] resolve(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] v;
      v = r_regs[addr];
      if (w_wb_fwd_ok && (wb_addr == addr)) v = wb_data;
      if ((FWD_EN != 0) && w_mem_fwd_ok && (mem_dst == addr)) v = mem_data;
      if ((FWD_EN != 0) && w_ex_fwd_ok && (r_ex_dst == addr)) v = ex_result;
      if (addr == '0) v = '0;
      return v;
   endfunction

   always_comb begin
      w_op_a = resolve(id_rs);
      w_op_b = resolve(id_rt);
   end

   assign w_ex_hit  = (r_ex_dst != '0) &
                      ((id_rs_used & (id_rs == r_ex_dst)) | (id_rt_used & (id_rt == r_ex_dst)));
   assign w_mem_hit = (mem_dst != '0) &
                      ((id_rs_used & (id_rs == mem_dst)) | (id_rt_used & (id_rt == mem_dst)));

   assign w_load_use = r_ex_valid & r_ex_memrd & r_ex_regwr & w_ex_hit;
   assign w_ex_raw   = r_ex_valid & r_ex_regwr & w_ex_hit;
   assign w_mem_raw  = mem_regwr & w_mem_hit;
   assign w_hazard   = (FWD_EN != 0) ? w_load_use : (w_ex_raw | w_mem_raw);

   // Flush outranks a stall: the killed instruction must not hold the front end.
   assign w_stall  = w_hazard & id_valid & ~flush;
   assign w_bubble = flush | w_stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ex_valid <= 1'b0;
         r_ex_ctrl  <= '0;
         r_ex_a     <= '0;
         r_ex_b     <= '0;
         r_ex_imm   <= '0;
         r_ex_pc    <= '0;
         r_ex_dst   <= '0;
         r_ex_regwr <= 1'b0;
         r_ex_memrd <= 1'b0;
      end else if (w_bubble) begin
         r_ex_valid <= 1'b0;
         r_ex_ctrl  <= '0;
         r_ex_a     <= '0;
         r_ex_b     <= '0;
         r_ex_imm   <= '0;
         r_ex_pc    <= '0;
         r_ex_dst   <= '0;
         r_ex_regwr <= 1'b0;
         r_ex_memrd <= 1'b0;
      end else begin
         r_ex_valid <= id_valid;
         r_ex_ctrl  <= id_ctrl;
         r_ex_a     <= w_op_a;
         r_ex_b     <= w_op_b;
         r_ex_imm   <= id_imm;
         r_ex_pc    <= id_pc;
         r_ex_dst   <= id_dst;
         r_ex_regwr <= id_regwr & id_valid;
         r_ex_memrd <= id_memrd & id_valid;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_out = w_stall;
   assign ex_valid  = r_ex_valid;
   assign ex_ctrl   = r_ex_ctrl;
   assign ex_a      = r_ex_a;
   assign ex_b      = r_ex_b;
   assign ex_imm    = r_ex_imm;
   assign ex_pc     = r_ex_pc;
   assign ex_dst    = r_ex_dst;
   assign ex_regwr  = r_ex_regwr;
   assign ex_memrd  = r_ex_memrd;
   assign stall_cnt = r_stall_cnt;

endmodule
